rr_encoder32x5: RTL and testbench



---
 rtl/rr_encoder32x5_pkg.sv | 14 +
 rtl/rr_encoder32x5_pick.sv | 29 ++
 rtl/rr_encoder32x5.sv | 59 +++++
 tb/tb_rr_encoder32x5.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_encoder32x5_pkg.sv
// Shared constants and result type for the round-robin request encoder.
// Default sizes, FSM state encodings and the registered result layout.
package rr_encoder32x5_pkg;
  localparam int N_DEF = 32;
  localparam int W_DEF = 5;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef struct packed {
    logic [W_DEF-1:0] idx;
    logic             multi;
  } res_t;
endpackage

// File: rtl/rr_encoder32x5_pick.sv
// Circular first-one search starting at ptr, done as a double-width scan.
// The upper copy of req supplies the wrapped candidates below ptr.
module rr_pick #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] g,
  output logic         found,
  output logic         multi
);
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [W:0]     idx;

  always_comb begin
    mask  = ~((N'(1) << ptr) - N'(1));
    dbl   = {req, req & mask};
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) idx = (W+1)'(i);
    end
    g     = idx[W-1:0];
    found = |req;
    multi = |(req & (req - N'(1)));
  end
endmodule

// File: rtl/rr_encoder32x5.sv
// Registered round-robin request encoder with valid/ready on both sides.
// Holds the EMPTY/FULL state, the rotating pointer and the result register.
import rr_encoder32x5_pkg::*;

module rr_encoder32x5 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_DEF-1:0] REQ,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [W_DEF-1:0] OUT,
  output logic             MULTI,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int N = N_DEF;
  localparam int W = W_DEF;

  logic         state;
  logic [W-1:0] ptr;
  res_t         res;
  logic [W-1:0] g;
  logic         found;
  logic         multi;
  logic         accept;
  logic         load;

  rr_pick #(.N(N), .W(W)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .g     (g),
    .found (found),
    .multi (multi)
  );

  assign out_valid = (state == ST_FULL);
  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;
  // Zero or disabled vectors are consumed without touching ptr or the result.
  assign load      = accept && enable && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      ptr   <= '0;
      res   <= '0;
    end else if (load) begin
      res   <= '{idx: g, multi: multi};
      ptr   <= g + W'(1);
      state <= ST_FULL;
    end else if (out_valid && out_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign OUT   = res.idx;
  assign MULTI = res.multi;
endmodule

// File: tb/tb_rr_encoder32x5.sv
// Scenario bench for rr_encoder32x5: expected grants queued at drive time,
// popped and compared when the encoder presents a new result.
module tb_rr_encoder32x5;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] req = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  out;
  logic        multi;
  logic        out_valid;
  logic        out_ready = 1'b0;

  typedef struct {
    logic [4:0] o;
    logic       m;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rr_encoder32x5 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .REQ       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .OUT       (out),
    .MULTI     (multi),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic push(input logic [4:0] o, input logic m);
    exp_t x;
    x.o = o;
    x.m = m;
    q.push_back(x);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    req = 'x;
    enable = 1'b0;
    out_ready = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req = 32'h0000_0010; req_valid = 1'b1; enable = 1'b1;
    edge_wait();
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 5'd0) begin n_bad++; $display("FAIL reset_out got %0d want 0", out); end
    n_cmp++; if (multi !== 1'b0) begin n_bad++; $display("FAIL reset_multi got %b want 0", multi); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    // ptr was 5 before reset; a fresh search must start at bit 0 again
    req = 32'h0000_0011; req_valid = 1'b1; enable = 1'b1;
    push(5'd0, 1'b1);
    edge_wait();
    req_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL reset_ptr got %0d/%b want %0d/%b", out, multi, e.o, e.m); end
  endtask

  task automatic test_one_hot();
    do_reset();
    req = 32'h0000_0010; req_valid = 1'b1; enable = 1'b1; out_ready = 1'b0;
    push(5'd4, 1'b0);
    edge_wait();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL onehot_valid got %b want 1", out_valid); end
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL onehot_out got %0d/%b want %0d/%b", out, multi, e.o, e.m); end
    @(negedge clk);
    req = 32'h0000_0021; out_ready = 1'b1;
    push(5'd5, 1'b1);
    edge_wait();
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m || out_valid !== 1'b1) begin n_bad++; $display("FAIL onehot_next got %0d/%b/%b want %0d/%b/1", out, multi, out_valid, e.o, e.m); end
    req_valid = 1'b0;
  endtask

  task automatic test_rr_wrap();
    do_reset();
    req = 32'h8000_0011; req_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
    push(5'd0, 1'b1); push(5'd4, 1'b1); push(5'd31, 1'b1); push(5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      edge_wait();
      e = q.pop_front();
      n_cmp++; if (out !== e.o || multi !== e.m || out_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_%0d got %0d/%b/%b want %0d/%b/1", i, out, multi, out_valid, e.o, e.m); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 32'h0000_0100; req_valid = 1'b1; enable = 1'b1; out_ready = 1'b0;
    push(5'd8, 1'b0);
    edge_wait();
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL bp_first got %0d/%b want %0d/%b", out, multi, e.o, e.m); end
    req = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d got %b want 0", i, req_ready); end
      edge_wait();
      n_cmp++; if (out !== 5'd8 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_%0d got %0d/%b want 8/1", i, out, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
    push(5'd0, 1'b0);
    edge_wait();
    req_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next got %0d/%b/%b want %0d/%b/1", out, multi, out_valid, e.o, e.m); end
  endtask

  task automatic test_discard();
    do_reset();
    req = 32'h0; req_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL discard_zero_ready got %b want 1", req_ready); end
    edge_wait();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL discard_zero_valid got %b want 0", out_valid); end
    req = 32'h0000_0002; enable = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL discard_dis_ready got %b want 1", req_ready); end
    edge_wait();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL discard_dis_valid got %b want 0", out_valid); end
    req = 32'h0000_0003; enable = 1'b1;
    push(5'd0, 1'b1);
    edge_wait();
    req_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m || out_valid !== 1'b1) begin n_bad++; $display("FAIL discard_after got %0d/%b/%b want %0d/%b/1", out, multi, out_valid, e.o, e.m); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 32'h8000_0000; req_valid = 1'b1; enable = 1'b1; out_ready = 1'b0;
    push(5'd31, 1'b0);
    edge_wait();
    req_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL mid_load got %0d/%b want %0d/%b", out, multi, e.o, e.m); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out !== 5'd0) begin n_bad++; $display("FAIL mid_reset got %0d/%b want 0/0", out, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    req = 32'h8000_0001; req_valid = 1'b1; out_ready = 1'b1;
    push(5'd0, 1'b1);
    edge_wait();
    req_valid = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL mid_after got %0d/%b want %0d/%b", out, multi, e.o, e.m); end
  endtask

  task automatic test_back_to_back();
    int   mp;
    logic ev;
    logic [4:0] gi;
    int   cnt;
    do_reset();
    mp = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req = (i % 7 == 3) ? 32'h0 : $urandom;
      if (i % 5 == 1) req = req & 32'h8000_0101;
      req_valid = 1'b1;
      enable = (i % 9 != 4);
      ev = 1'b0;
      if (enable && req != 0) begin
        ev = 1'b1;
        gi = '0;
        for (int k = 31; k >= 0; k--) if (req[(mp + k) % 32]) gi = 5'((mp + k) % 32);
        cnt = 0;
        for (int k = 0; k < 32; k++) cnt += int'(req[k]);
        push(gi, cnt > 1);
        mp = (int'(gi) + 1) % 32;
      end
      edge_wait();
      n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL b2b_valid_%0d got %b want %b", i, out_valid, ev); end
      if (ev) begin
        e = q.pop_front();
        n_cmp++; if (out !== e.o || multi !== e.m) begin n_bad++; $display("FAIL b2b_out_%0d got %0d/%b want %0d/%b", i, out, multi, e.o, e.m); end
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_hot();
    test_rr_wrap();
    test_backpressure();
    test_discard();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
